// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU opcodes and ID/EX control bundle.
package cpu_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned RW_DEF = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    // Control portion of the ID/EX register
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ex_ctrl_t;

    // A bubble does nothing: no valid, no side effects, ALU doing an add
    localparam ex_ctrl_t BUBBLE_CTRL = '{
        valid:      1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_op:     ALU_ADD
    };

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB,
// register 0 is never forwarded.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] fwd_data
);

    // Priority select of the newest in-flight producer of idx
    always_comb begin
        fwd_data = reg_data;
        if (idx != '0) begin
            if (exmem_reg_write && (exmem_rd == idx)) begin
                fwd_data = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == idx)) begin
                fwd_data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded fields, forwards
// later-stage results into the operands, detects load-use hazards and
// inserts bubbles on stall or flush.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_alu_op,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          stall,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [3:0]    alu_op,
    output logic [4:0]    alu_shamt,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg
);

    ex_ctrl_t      ctrl_q,    ctrl_d;
    logic [RW-1:0] rs_q,      rs_d;
    logic [RW-1:0] rt_q,      rt_d;
    logic [RW-1:0] rd_q,      rd_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q,     imm_d;
    logic [4:0]    shamt_q,   shamt_d;

    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // Load-use hazard: a load in EX whose destination is read by ID; a flush
    // kills the ID instruction anyway, so it masks the stall
    always_comb begin
        stall = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                ((rd_q == id_rs) || (rd_q == id_rt)) && !flush;
    end

    // Next register contents: bubble on flush/stall, otherwise capture ID
    always_comb begin
        ctrl_d.valid      = id_valid;
        ctrl_d.reg_write  = id_reg_write  & id_valid;
        ctrl_d.mem_read   = id_mem_read   & id_valid;
        ctrl_d.mem_write  = id_mem_write  & id_valid;
        ctrl_d.mem_to_reg = id_mem_to_reg & id_valid;
        ctrl_d.alu_src    = id_alu_src;
        ctrl_d.alu_op     = id_alu_op;
        rs_d      = id_rs;
        rt_d      = id_rt;
        rd_d      = id_rd;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm;
        shamt_d   = id_shamt;
        if (flush || stall) begin
            ctrl_d    = BUBBLE_CTRL;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            shamt_d   = '0;
        end
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            shamt_q   <= shamt_d;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx             (rs_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (rs_fwd)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx             (rt_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (rt_fwd)
    );

    // EX-side outputs: operands from forwarding, controls straight from the register
    always_comb begin
        alu_in1       = rs_fwd;
        alu_in2       = ctrl_q.alu_src ? imm_q : rt_fwd;
        ex_store_data = rt_fwd;
        alu_op        = ctrl_q.alu_op;
        alu_shamt     = shamt_q;
        ex_rd         = rd_q;
        ex_valid      = ctrl_q.valid;
        ex_reg_write  = ctrl_q.reg_write;
        ex_mem_read   = ctrl_q.mem_read;
        ex_mem_write  = ctrl_q.mem_write;
        ex_mem_to_reg = ctrl_q.mem_to_reg;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed vector table followed
// by randomized traffic compared against an instruction-level reference model.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_operand_stage #(.DW(32), .RW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_shamt        (id_shamt),
        .id_alu_op       (id_alu_op),
        .id_alu_src      (id_alu_src),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .stall           (stall),
        .alu_in1         (alu_in1),
        .alu_in2         (alu_in2),
        .alu_op          (alu_op),
        .alu_shamt       (alu_shamt),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rst, flush, v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [3:0]  op;
        logic        src, rw, mr, mw;
        logic        xw;  logic [4:0] xrd; logic [31:0] xres;
        logic        ww;  logic [4:0] wrd; logic [31:0] wres;
        logic        chk_stall;
        logic        e_stall, e_valid, e_rw, e_mr, e_mw;
        logic [3:0]  e_op;
        logic [4:0]  e_rd;
        logic [31:0] e_in1, e_in2, e_sd;
    } vec_t;

    function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                                logic [3:0] op, logic src, logic rw, logic mr, logic mw);
        vec_t t = '{default: '0};
        t.v = v; t.rs = rs; t.rt = rt; t.rd = rd;
        t.rsd = rsd; t.rtd = rtd; t.imm = imm;
        t.op = op; t.src = src; t.rw = rw; t.mr = mr; t.mw = mw;
        t.chk_stall = 1'b1;
        return t;
    endfunction

    function automatic vec_t ex(vec_t t, logic st, logic val, logic rw, logic mr, logic mw,
                                logic [3:0] op, logic [4:0] rd,
                                logic [31:0] i1, logic [31:0] i2, logic [31:0] sd);
        vec_t r = t;
        r.e_stall = st; r.e_valid = val; r.e_rw = rw; r.e_mr = mr; r.e_mw = mw;
        r.e_op = op; r.e_rd = rd; r.e_in1 = i1; r.e_in2 = i2; r.e_sd = sd;
        return r;
    endfunction

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] op,
                            input logic src, input logic rw, input logic mr, input logic mw,
                            input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
        id_alu_op = op; id_alu_src = src; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    vec_t vecs[$];

    // ---------------- reference model state ----------------
    // The instruction currently sitting in EX, as a plain record
    typedef struct {
        logic        valid, rw, mr, mw, m2r, src;
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] rsd, rtd, imm;
    } instr_t;

    function automatic logic [31:0] operand(logic [4:0] idx, logic [31:0] regval,
                                            logic xw, logic [4:0] xrd, logic [31:0] xres,
                                            logic ww, logic [4:0] wrd, logic [31:0] wres);
        if (idx == 5'd0) return regval;
        if (xw && xrd == idx) return xres;
        if (ww && wrd == idx) return wres;
        return regval;
    endfunction

    initial begin
        vec_t   v;
        instr_t m, nxt;
        logic   exp_stall;
        logic [31:0] e1, e2, esd;

        rst = 1'b0; flush = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;

        // reset twice with a live instruction at the inputs
        v = mk(1, 3, 4, 5, 32'h1, 32'h2, 0, 4'h1, 0, 1, 0, 0);
        v.rst = 1; v.chk_stall = 0;
        v = ex(v, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        vecs.push_back(v);
        v.chk_stall = 1;
        vecs.push_back(v);
        // plain capture
        v = mk(1, 1, 2, 3, 32'd5, 32'd7, 0, 4'h1, 0, 1, 0, 0);
        vecs.push_back(ex(v, 0, 1, 1, 0, 0, 4'h1, 3, 32'd5, 32'd7, 32'd7));
        // forward priority on rs=3
        v = mk(1, 3, 0, 6, 32'hAA, 32'hBB, 0, 4'h2, 0, 1, 0, 0);
        v.xw = 1; v.xrd = 3; v.xres = 32'h11; v.ww = 1; v.wrd = 3; v.wres = 32'h22;
        vecs.push_back(ex(v, 0, 1, 1, 0, 0, 4'h2, 6, 32'h11, 32'hBB, 32'hBB));
        v.xw = 0;
        vecs.push_back(ex(v, 0, 1, 1, 0, 0, 4'h2, 6, 32'h22, 32'hBB, 32'hBB));
        // r0 never forwarded
        v = mk(1, 0, 0, 6, 32'h33, 32'h44, 0, 4'h2, 0, 1, 0, 0);
        v.xw = 1; v.xrd = 0; v.xres = 32'h55; v.ww = 1; v.wrd = 0; v.wres = 32'h66;
        vecs.push_back(ex(v, 0, 1, 1, 0, 0, 4'h2, 6, 32'h33, 32'h44, 32'h44));
        // lw r8, 4(r1)
        v = mk(1, 1, 8, 8, 32'h100, 32'h0, 32'd4, 4'h0, 1, 1, 1, 0);
        vecs.push_back(ex(v, 0, 1, 1, 1, 0, 4'h0, 8, 32'h100, 32'd4, 32'h0));
        // consumer of r8: stall, bubble, then captured
        v = mk(1, 2, 8, 9, 32'd1, 32'd2, 0, 4'h0, 0, 1, 0, 0);
        vecs.push_back(ex(v, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(ex(v, 0, 1, 1, 0, 0, 4'h0, 9, 32'd1, 32'd2, 32'd2));
        // lw again, then the consumer arrives together with a flush
        vecs.push_back(vecs[6]);
        v.flush = 1;
        vecs.push_back(ex(v, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        // store with immediate operand and forwarded store data
        v = mk(1, 1, 4, 0, 32'h10, 32'h44, 32'hFFFF_FFFC, 4'h0, 1, 0, 0, 1);
        v.xw = 1; v.xrd = 4; v.xres = 32'h99;
        vecs.push_back(ex(v, 0, 1, 0, 0, 1, 4'h0, 0, 32'h10, 32'hFFFF_FFFC, 32'h99));
        // invalid slot: controls forced off
        v = mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 1);
        vecs.push_back(ex(v, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        // reset arriving while a stall is asserted
        vecs.push_back(vecs[6]);
        v = mk(1, 2, 8, 9, 32'd1, 32'd2, 0, 4'h0, 0, 1, 0, 0);
        v.rst = 1;
        vecs.push_back(ex(v, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        v.rst = 0;
        vecs.push_back(ex(v, 0, 1, 1, 0, 0, 4'h0, 9, 32'd1, 32'd2, 32'd2));

        foreach (vecs[i]) begin
            v = vecs[i];
            rst = v.rst; flush = v.flush;
            drive_id(v.v, v.rs, v.rt, v.rd, v.rsd, v.rtd, v.imm, 5'd0, v.op,
                     v.src, v.rw, v.mr, v.mw, v.mr);
            exmem_reg_write = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
            memwb_reg_write = v.ww; memwb_rd = v.wrd; memwb_result = v.wres;
            #2;
            if (v.chk_stall) chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, v.e_stall});
            @(posedge clk); #1;
            chk($sformatf("v%0d ex_valid", i),     {31'd0, ex_valid},      {31'd0, v.e_valid});
            chk($sformatf("v%0d ex_reg_write", i), {31'd0, ex_reg_write},  {31'd0, v.e_rw});
            chk($sformatf("v%0d ex_mem_read", i),  {31'd0, ex_mem_read},   {31'd0, v.e_mr});
            chk($sformatf("v%0d ex_mem_to_reg", i),{31'd0, ex_mem_to_reg}, {31'd0, v.e_mr});
            chk($sformatf("v%0d ex_mem_write", i), {31'd0, ex_mem_write},  {31'd0, v.e_mw});
            chk($sformatf("v%0d alu_op", i),       {28'd0, alu_op},        {28'd0, v.e_op});
            chk($sformatf("v%0d ex_rd", i),        {27'd0, ex_rd},         {27'd0, v.e_rd});
            chk($sformatf("v%0d alu_in1", i),      alu_in1,                v.e_in1);
            chk($sformatf("v%0d alu_in2", i),      alu_in2,                v.e_in2);
            chk($sformatf("v%0d store_data", i),   ex_store_data,          v.e_sd);
        end

        // ---------------- randomized traffic ----------------
        m = '{default: '0};
        for (int i = 0; i < 400; i++) begin
            rst   = (i == 0) || ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive_id($urandom_range(0, 3) != 0,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 8)),
                     1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
                     1'($urandom));
            #2;
            exp_stall = !flush && m.valid && m.mr && (m.rd != 0) && id_valid &&
                        (m.rd == id_rs || m.rd == id_rt);
            if (i > 0) chk("rnd stall", {31'd0, stall}, {31'd0, exp_stall});

            if (rst || flush || exp_stall) begin
                nxt = '{default: '0};
            end else begin
                nxt.valid = id_valid;
                nxt.rw  = id_reg_write  && id_valid;
                nxt.mr  = id_mem_read   && id_valid;
                nxt.mw  = id_mem_write  && id_valid;
                nxt.m2r = id_mem_to_reg && id_valid;
                nxt.src = id_alu_src; nxt.op = id_alu_op; nxt.sh = id_shamt;
                nxt.rs = id_rs; nxt.rt = id_rt; nxt.rd = id_rd;
                nxt.rsd = id_rs_data; nxt.rtd = id_rt_data; nxt.imm = id_imm;
            end
            @(posedge clk); #1;
            m = nxt;

            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
            #1;
            e1  = operand(m.rs, m.rsd, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);
            esd = operand(m.rt, m.rtd, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);
            e2  = m.src ? m.imm : esd;

            chk("rnd ex_valid",     {31'd0, ex_valid},      {31'd0, m.valid});
            chk("rnd ex_reg_write", {31'd0, ex_reg_write},  {31'd0, m.rw});
            chk("rnd ex_mem_read",  {31'd0, ex_mem_read},   {31'd0, m.mr});
            chk("rnd ex_mem_write", {31'd0, ex_mem_write},  {31'd0, m.mw});
            chk("rnd ex_mem_to_reg",{31'd0, ex_mem_to_reg}, {31'd0, m.m2r});
            if (m.valid) begin
                chk("rnd alu_op",     {28'd0, alu_op},    {28'd0, m.op});
                chk("rnd ex_rd",      {27'd0, ex_rd},     {27'd0, m.rd});
                chk("rnd alu_shamt",  {27'd0, alu_shamt}, {27'd0, m.sh});
                chk("rnd alu_in1",    alu_in1,            e1);
                chk("rnd alu_in2",    alu_in2,            e2);
                chk("rnd store_data", ex_store_data,      esd);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
